// File: rtl/bram_responder.sv
// Small BRAM that a host fills in ascending order (LOAD), then serves control-unit reads/writes (SERVE).
// Read latency 1, or 2 when BRAM_OUT_REG_EN is defined; fill port is held off (load_ready=0) once full.
module bram_responder #(
  parameter int BRAM_DEPTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_cu,
  input  logic                  write_mode,
  input  logic [BRAM_DEPTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  mem_full,
  output logic                  access_err
);

  typedef enum logic {LOAD, SERVE} state_t;

  localparam logic [BRAM_DEPTH-1:0] PTR_LAST = '1;

  state_t                state_q;
  logic [BRAM_DEPTH-1:0] load_ptr_q;
  logic [BRAM_DEPTH-1:0] load_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  access_err_q;
  logic [DATA_WIDTH-1:0] mem [2**BRAM_DEPTH];

  logic load_wr;
  logic cu_acc;
  logic cu_wr;
  logic cu_rd;

  // Reset and flush both squash any access presented in the same cycle.
  assign load_wr    = (state_q == LOAD) && load_valid && !flush && !reset;
  assign cu_acc     = (state_q == SERVE) && enable_cu && !flush && !reset;
  assign cu_wr      = cu_acc && write_mode;
  assign cu_rd      = cu_acc && !write_mode;
  assign load_ptr_d = load_ptr_q + BRAM_DEPTH'(1);

  // Storage has no reset so contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem[load_ptr_q] <= load_data;
    end else if (cu_wr) begin
      mem[address] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      access_err_q <= 1'b0;
    end else if (flush) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= cu_rd;
      if (cu_rd) begin
        rd_data_q <= mem[address];
      end
      case (state_q)
        LOAD: begin
          if (enable_cu) begin
            access_err_q <= 1'b1;
          end
          if (load_valid) begin
            load_ptr_q <= load_ptr_d;
            if (load_ptr_q == PTR_LAST) begin
              state_q <= SERVE;
            end
          end
        end
        default: begin
          state_q <= SERVE;
        end
      endcase
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  // Second stage only captures valid data so rd_data still holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        out_data_q <= rd_data_q;
      end
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign load_ready = (state_q == LOAD);
  assign mem_full   = (state_q == SERVE);
  assign access_err = access_err_q;

endmodule

// File: tb/tb_bram_responder.sv
// Directed scoreboard bench for bram_responder: reads push expected data and due cycle,
// a negedge monitor pops and compares on every rd_valid pulse.
module tb_bram_responder;

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_cu;
  logic       write_mode;
  logic [1:0] address;
  logic [7:0] wr_data;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       flush;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       mem_full;
  logic       access_err;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  bram_responder #(.BRAM_DEPTH(2), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_cu  (enable_cu),
    .write_mode (write_mode),
    .address    (address),
    .wr_data    (wr_data),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .flush      (flush),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .mem_full   (mem_full),
    .access_err (access_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rd_valid must match the oldest expectation, at its due cycle.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rd_valid cyc=%0d rd_data=%h required=no response", cyc, rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rd_data !== e.d || cyc != e.c) begin
          bad++;
          $display("FAIL rd_resp got data=%h cyc=%0d required data=%h cyc=%0d", rd_data, cyc, e.d, e.c);
        end
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].c) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_rd_valid cyc=%0d required data=%h at cyc=%0d", cyc, e.d, e.c);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    enable_cu  = 1'b1;
    write_mode = 1'b0;
    address    = a;
    e.d = d;
    e.c = cyc + LAT;
    exp_q.push_back(e);
    cycle();
    enable_cu = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    enable_cu  = 1'b1;
    write_mode = 1'b1;
    address    = a;
    wr_data    = d;
    cycle();
    enable_cu  = 1'b0;
    write_mode = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired cyc=%0d required=bench completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable_cu = 1'b0; write_mode = 1'b0; address = '0;
    wr_data = '0; load_valid = 1'b0; load_data = '0; flush = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_load_ready", load_ready, 1);
    chk("reset_mem_full", mem_full, 0);
    chk("reset_access_err", access_err, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 8'h00);

    // Partial fill interrupted by reset: pointer must restart at 0.
    load(8'h99);
    load(8'h88);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("midfill_reset_load_ready", load_ready, 1);

    // Access while in LOAD: flagged, no response.
    enable_cu = 1'b1; write_mode = 1'b0; address = 2'd0;
    cycle();
    enable_cu = 1'b0;
    @(negedge clk);
    chk("load_access_err", access_err, 1);

    load(8'h11);
    load(8'h22);
    load(8'h33);
    @(negedge clk);
    chk("fill3_mem_full", mem_full, 0);
    chk("fill3_load_ready", load_ready, 1);
    load(8'h44);
    @(negedge clk);
    chk("fill4_mem_full", mem_full, 1);
    chk("fill4_load_ready", load_ready, 0);
    chk("fill4_access_err_sticky", access_err, 1);

    // Fill port is ignored in SERVE.
    load(8'hEE);

    rd(2'd3, 8'h44);
    rd(2'd0, 8'h11);
    rd(2'd2, 8'h33);
    wr(2'd1, 8'hAA);
    rd(2'd1, 8'hAA);
    rd(2'd3, 8'h44);
    cycle();
    cycle();
    cycle();
    @(negedge clk);
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_rd_data_hold", rd_data, 8'h44);

    // Flush collides with a read: read is dropped, LOAD re-entered.
    enable_cu = 1'b1; write_mode = 1'b0; address = 2'd2; flush = 1'b1;
    cycle();
    enable_cu = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_load_ready", load_ready, 1);
    chk("flush_mem_full", mem_full, 0);

    load(8'h01);
    load(8'h02);
    load(8'h03);
    load(8'h04);
    @(negedge clk);
    chk("refill_mem_full", mem_full, 1);
    rd(2'd0, 8'h01);
    rd(2'd1, 8'h02);
    rd(2'd2, 8'h03);
    rd(2'd3, 8'h04);

    repeat (5) cycle();
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_responder.md
BRAM_RESPONDER -- requirements
Module: bram_responder

Interface
REQ-001 Parameter BRAM_DEPTH, default 2, address width in bits; the memory holds 2**BRAM_DEPTH words.
REQ-002 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable_cu  input  1  access strobe from the control unit, one access per asserted cycle.
REQ-006 write_mode  input  1  0 = read, 1 = write; qualified by enable_cu.
REQ-007 address  input  BRAM_DEPTH  access address; qualified by enable_cu.
REQ-008 wr_data  input  DATA_WIDTH  write data for write accesses.
REQ-009 load_valid  input  1  host fill-port data valid.
REQ-010 load_data  input  DATA_WIDTH  host fill-port data.
REQ-011 load_ready  output  1  fill port accepts a word when high.
REQ-012 flush  input  1  synchronous return to the LOAD state.
REQ-013 rd_data  output  DATA_WIDTH  read response data.
REQ-014 rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-015 mem_full  output  1  high while in the SERVE state.
REQ-016 access_err  output  1  sticky flag: enable_cu was asserted while in the LOAD state.

Function
REQ-017 The FSM SHALL have two states: LOAD (fill via the host port) and SERVE (respond to the control unit).
REQ-018 In LOAD: load_ready = 1; each cycle with load_valid=1 writes load_data to mem[load_ptr], and load_ptr increments by 1.
REQ-019 load_ptr SHALL be BRAM_DEPTH bits wide, start at 0, and fill strictly in ascending order.
REQ-020 Accepting a word at load_ptr = 2**BRAM_DEPTH-1 SHALL move the FSM to SERVE on the next cycle and wrap load_ptr to 0.
REQ-021 In SERVE: load_ready = 0, and load_valid is ignored.
REQ-022 In SERVE, enable_cu=1 with write_mode=0 SHALL read mem[address].
- Without BRAM_OUT_REG_EN: rd_data and a rd_valid pulse appear on the next cycle (latency 1).
REQ-023 In SERVE, enable_cu=1 with write_mode=1 SHALL write wr_data to mem[address].
- No rd_valid is produced.
REQ-024 A read of an address in the cycle immediately after a write to that address SHALL return the newly written data.
REQ-025 rd_data SHALL hold its last value when rd_valid=0.
REQ-026 Back-to-back reads on consecutive cycles SHALL each produce a response (full throughput, in order).
REQ-027 In LOAD, enable_cu=1 SHALL perform no access, produce no rd_valid, and set access_err=1.
- access_err stays set until reset.
REQ-028 flush=1 SHALL move the FSM to LOAD next cycle, clear load_ptr, and drop any in-flight rd_valid.
- flush has priority over a simultaneous enable_cu access or load write; that access or write is discarded.
REQ-029 Memory contents SHALL survive flush and reset; they are not cleared.

Reset
REQ-030 On reset: state = LOAD, load_ptr = 0, rd_data = 0, rd_valid = 0, access_err = 0.
- Resulting outputs: load_ready = 1, mem_full = 0.
REQ-031 Reset SHALL have priority over flush and all accesses, and SHALL cancel any in-flight read.

Configuration
REQ-032 With macro BRAM_OUT_REG_EN defined, an extra output register stage SHALL be added.
- Read latency becomes 2; rd_valid stays aligned with rd_data.
- Throughput remains one read per cycle.
- flush and reset cancel both pipeline stages.
REQ-033 With BRAM_OUT_REG_EN undefined, read latency SHALL be 1 and no extra register is present.

Verification
REQ-034 Reset, then load 0x11, 0x22, 0x33, 0x44 -> mem_full=1 on the cycle after 0x44 is accepted, and load_ready=0.
REQ-035 In SERVE, reads of addresses 3, 0, 2 on consecutive cycles -> rd_data 0x44, 0x11, 0x33 on three consecutive rd_valid pulses, at latency 1 (2 with BRAM_OUT_REG_EN).
REQ-036 Write 0xAA to address 1, then read address 1 next cycle -> rd_data=0xAA.
REQ-037 enable_cu=1 after reset, before the fill completes -> access_err=1, no rd_valid, and access_err still 1 after the fill completes.
REQ-038 flush in the same cycle as a read of address 2 -> no rd_valid; LOAD entered with load_ready=1; load_ptr restarts at 0.
REQ-039 Reset during the fill after 2 words, then refill 4 words -> the words land at addresses 0-3 and mem_full rises only after the 4th word.
